// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one backing-memory port between the instruction refill
// path (port I, read-only) and the data refill/write-back path (port D).
// One transaction in flight at a time, round-robin on ties, optional timeout.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | no transaction; arbitrate i_req/d_req, latch the winner
// REQ    | mem_req held with latched fields; waiting for mem_ready/timeout
// ACK    | one-cycle ack pulse to the winner, err valid; update last winner
module mem_arbiter #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [XLEN-1:0] i_addr,
    output logic            i_ack,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [3:0]      d_be,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_ack,
    output logic [XLEN-1:0] rdata,
    output logic            err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    // Count value of the last REQ cycle allowed before aborting; only
    // meaningful when TIMEOUT is non-zero.
    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);
    localparam bit            TO_EN    = (TIMEOUT != 0);

    state_t          state_q, state_d;
    logic            last_q, last_d;
    logic            port_q, port_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [3:0]      mem_be_q, mem_be_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [TW-1:0]   cnt_q, cnt_d;

    logic            grant_i;
    logic            grant_d;

    // Round-robin grant: a lone request wins, on a tie the port that did not
    // win last time goes first.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (i_req && d_req) begin
            grant_i = (last_q == PORT_D);
            grant_d = (last_q == PORT_I);
        end else begin
            grant_i = i_req;
            grant_d = d_req;
        end
    end

    // Next-state and datapath logic for the IDLE/REQ/ACK sequence.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        port_d      = port_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (grant_i) begin
                    port_d      = PORT_I;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_be_d    = 4'hF;
                    mem_addr_d  = i_addr;
                    mem_wdata_d = '0;
                    cnt_d       = '0;
                    state_d     = S_REQ;
                end else if (grant_d) begin
                    port_d      = PORT_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    // Reads always fetch the full word.
                    mem_be_d    = d_we ? d_be : 4'hF;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    cnt_d       = '0;
                    state_d     = S_REQ;
                end
            end

            S_REQ: begin
                // mem_ready wins over a timeout landing in the same cycle.
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    err_d     = 1'b0;
                    if (!mem_we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = S_ACK;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    mem_req_d = 1'b0;
                    rdata_d   = '0;
                    err_d     = 1'b1;
                    state_d   = S_ACK;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end

            S_ACK: begin
                last_d  = port_q;
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                mem_req_d = 1'b0;
                err_d     = 1'b0;
                cnt_d     = '0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transaction silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            last_q      <= PORT_D;
            port_q      <= PORT_I;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'h0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            port_q      <= port_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    // Acks are decoded from the registered state, so they are one-cycle
    // pulses and can never be asserted together.
    always_comb begin
        i_ack     = (state_q == S_ACK) && (port_q == PORT_I);
        d_ack     = (state_q == S_ACK) && (port_q == PORT_D);
        busy      = (state_q != S_IDLE);
        err       = err_q;
        rdata     = rdata_q;
        mem_req   = mem_req_q;
        mem_we    = mem_we_q;
        mem_be    = mem_be_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected acks and memory
// requests; a monitor and a memory responder pop and compare.
module tb_mem_arbiter;

    localparam int TO = 8;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] rdata;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        busy;

    logic        mem_ready_r;
    logic        mem_ready_frc;
    assign mem_ready = mem_ready_r | mem_ready_frc;

    mem_arbiter #(.XLEN(32), .TIMEOUT(TO), .TW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .rdata     (rdata),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    typedef struct {
        logic        port;
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } ack_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          len;
    } mem_t;

    ack_t ack_q[$];
    mem_t mem_q[$];

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    logic        resp_en    = 1'b0;
    int          resp_lat   = 0;
    logic        resp_fixed = 1'b1;
    logic [31:0] resp_data  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Memory model: checks each new request, answers after resp_lat cycles.
    initial begin
        automatic logic in_txn = 1'b0;
        automatic int   wcnt   = 0;
        automatic int   hi     = 0;
        automatic int   cur_len = -1;
        mem_t m;
        mem_ready_r = 1'b0;
        mem_rdata   = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_ready_r) mem_ready_r = 1'b0;
            if (mem_req) begin
                if (!in_txn) begin
                    in_txn = 1'b1;
                    wcnt   = 0;
                    hi     = 0;
                    if (mem_q.size() == 0) begin
                        chk("unexpected_mem_req", 32'd1, 32'd0);
                        cur_len = -1;
                    end else begin
                        m = mem_q.pop_front();
                        cur_len = m.len;
                        chk("mem_addr", mem_addr, m.addr);
                        chk("mem_we", {31'd0, mem_we}, {31'd0, m.we});
                        chk("mem_be", {28'd0, mem_be}, {28'd0, m.be});
                        if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
                    end
                end
                hi++;
                if (resp_en && wcnt == resp_lat) begin
                    mem_ready_r = 1'b1;
                    mem_rdata   = resp_fixed ? resp_data : (mem_addr ^ 32'h5A5A_0000);
                end else begin
                    wcnt++;
                end
            end else if (in_txn) begin
                in_txn = 1'b0;
                if (cur_len >= 0) chk("mem_req_len", hi, cur_len);
            end
        end
    end

    // Ack monitor: pops one expectation per ack pulse.
    initial begin
        ack_t a;
        forever begin
            @(negedge clk);
            if (rst && (i_ack || d_ack)) begin
                chk("ack_exclusive", {31'd0, i_ack & d_ack}, 32'd0);
                if (ack_q.size() == 0) begin
                    chk("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    a = ack_q.pop_front();
                    chk("ack_port", {31'd0, d_ack}, {31'd0, a.port});
                    chk("ack_err", {31'd0, err}, {31'd0, a.err});
                    chk("ack_rdata", rdata, a.rdata);
                    chk("ack_cycle", cyc, a.cyc);
                end
            end
        end
    end

    task automatic wait_acks(input int n);
        automatic int seen = 0;
        for (int k = 0; k < 60 && seen < n; k++) begin
            @(negedge clk);
            if (i_ack || d_ack) seen++;
        end
        chk("ack_wait", seen, n);
        @(posedge clk);
        #1;
    endtask

    task automatic push_mem(input logic [31:0] addr, input logic we, input logic [3:0] be,
                            input logic [31:0] wdata, input int len);
        mem_t m;
        m.addr = addr; m.we = we; m.be = be; m.wdata = wdata; m.len = len;
        mem_q.push_back(m);
    endtask

    task automatic push_ack(input logic port, input logic e, input logic [31:0] rd, input int c);
        ack_t a;
        a.port = port; a.err = e; a.rdata = rd; a.cyc = c;
        ack_q.push_back(a);
    endtask

    // One transaction on port I (port=0) or D (port=1).
    task automatic txn(input logic port, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic en, input int lat, input logic [31:0] data,
                       input logic exp_err, input logic [31:0] exp_rd);
        automatic int len = en ? lat + 1 : TO;
        @(posedge clk);
        #1;
        resp_en = en; resp_lat = lat; resp_fixed = 1'b1; resp_data = data;
        push_mem(addr, port & we, (port & we) ? be : 4'hF, wdata, len);
        push_ack(port, exp_err, exp_rd, cyc + len + 1);
        if (port) begin
            d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        wait_acks(1);
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
        chk({tag, "_acks"}, {30'd0, i_ack, d_ack}, 32'd0);
        chk({tag, "_rdata"}, rdata, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    initial begin
        int n0;
        rst = 1'b0;
        mem_ready_frc = 1'b0;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_zero("reset");
        chk("reset_mem_be", {28'd0, mem_be}, 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Single I read, memory answers 3 cycles after the request.
        txn(1'b0, 1'b0, 4'h0, 32'h100, 32'h0, 1'b1, 3, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF);
        // D write, immediate ready; rdata keeps the previous read value.
        txn(1'b1, 1'b1, 4'b0011, 32'h204, 32'h1234, 1'b1, 0, 32'hFFFF_FFFF, 1'b0, 32'hDEADBEEF);

        // Reset in the middle of REQ: transaction dropped, no ack.
        @(posedge clk);
        #1;
        resp_en = 1'b0;
        push_mem(32'h500, 1'b0, 4'hF, 32'h0, -1);
        i_addr = 32'h500;
        i_req  = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        rst   = 1'b0;
        i_req = 1'b0;
        @(negedge clk);
        chk_idle_zero("midreset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        mem_ready_frc = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("stray_ready_busy", {31'd0, busy}, 32'd0);
            chk("stray_ready_rdata", rdata, 32'd0);
        end
        @(posedge clk);
        #1;
        mem_ready_frc = 1'b0;

        // Contention: both held, grants alternate I,D,I,D starting with I.
        @(posedge clk);
        #1;
        n0 = cyc;
        resp_en = 1'b1; resp_lat = 0; resp_fixed = 1'b0;
        push_mem(32'h300, 1'b0, 4'hF, 32'h0, 1);
        push_mem(32'h400, 1'b0, 4'hF, 32'h0, 1);
        push_mem(32'h300, 1'b0, 4'hF, 32'h0, 1);
        push_mem(32'h400, 1'b0, 4'hF, 32'h0, 1);
        push_ack(1'b0, 1'b0, 32'h5A5A_0300, n0 + 2);
        push_ack(1'b1, 1'b0, 32'h5A5A_0400, n0 + 5);
        push_ack(1'b0, 1'b0, 32'h5A5A_0300, n0 + 8);
        push_ack(1'b1, 1'b0, 32'h5A5A_0400, n0 + 11);
        i_addr = 32'h300; i_req = 1'b1;
        d_addr = 32'h400; d_we = 1'b0; d_be = 4'h0; d_req = 1'b1;
        wait_acks(4);
        i_req = 1'b0;
        d_req = 1'b0;

        // Timeout: memory never answers; err with rdata cleared.
        txn(1'b1, 1'b0, 4'h0, 32'h600, 32'h0, 1'b0, 0, 32'h0, 1'b1, 32'h0);
        // Ready in the exact timeout cycle counts as success, err back to 0.
        txn(1'b0, 1'b0, 4'h0, 32'h700, 32'h0, 1'b1, TO - 1, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D);
        // Ready one cycle earlier than the timeout cycle.
        txn(1'b1, 1'b0, 4'h0, 32'h704, 32'h0, 1'b1, TO - 2, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D);

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("end_idle_busy", {31'd0, busy}, 32'd0);
        chk("ack_queue_empty", ack_q.size(), 32'd0);
        chk("mem_queue_empty", mem_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
